mem_port_arbiter: RTL

- Shares one single-port, fixed-latency memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage load/store) of the 5-stage RV32I pipeline.
- Data requests have priority, because the MEM-stage instruction is older. A fairness counter stops fetch from starving.
- Each requester sees a req/ack handshake. The pipeline turns "req high and ack low" into its IF or MEM stall.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding, port select
// values and parameter legality helpers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_DM = 1'b1;

    localparam int MEM_LAT_MIN  = 1;
    localparam int MEM_LAT_MAX  = 15;
    localparam int FAIRNESS_MIN = 1;
    localparam int FAIRNESS_MAX = 15;

    function automatic bit in_range(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port fixed-latency memory between instruction fetch and
// data access; data has priority, bounded by a fairness streak counter.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int FAIRNESS = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    generate
        if (!in_range(MEM_LAT, MEM_LAT_MIN, MEM_LAT_MAX)) begin : g_bad_mem_lat
            $error("mem_port_arbiter: MEM_LAT out of range 1..15");
        end
        if (!in_range(FAIRNESS, FAIRNESS_MIN, FAIRNESS_MAX)) begin : g_bad_fairness
            $error("mem_port_arbiter: FAIRNESS out of range 1..15");
        end
    endgenerate

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);
    localparam logic [3:0] FAIR_MAX = 4'(FAIRNESS);

    // Data wins unless fetch is waiting and data has used up its streak.
    function automatic logic grant_dm(input logic dm_r, input logic if_r,
                                      input logic [3:0] streak);
        return dm_r && !(if_r && (streak == FAIR_MAX));
    endfunction

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic              we_q, we_d;
    logic [3:0]        lat_cnt_q, lat_cnt_d;
    logic [3:0]        dm_streak_q, dm_streak_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              busy_q, busy_d;
    logic              dm_win;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        we_d        = we_q;
        lat_cnt_d   = lat_cnt_q;
        dm_streak_d = dm_streak_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        dm_win      = 1'b0;

        case (state_q)
            IDLE: begin
                dm_win = grant_dm(dm_req, if_req, dm_streak_q);
                if (dm_win && if_req) begin
                    if (dm_streak_q != FAIR_MAX) begin
                        dm_streak_d = dm_streak_q + 4'd1;
                    end
                end else begin
                    dm_streak_d = 4'd0;
                end
                if (dm_win || if_req) begin
                    // Address/data registers feed the memory directly, so the
                    // access is presented in the cycle after arbitration.
                    sel_d       = dm_win ? SEL_DM : SEL_IF;
                    we_d        = dm_win && dm_we;
                    mem_addr_d  = dm_win ? dm_addr : if_addr;
                    mem_wdata_d = dm_win ? dm_wdata : '0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_win && dm_we;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                lat_cnt_d = LAT_INIT;
                state_d   = WAIT;
            end
            WAIT: begin
                if (lat_cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (sel_q == SEL_DM) begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = we_q ? '0 : mem_rdata;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            sel_q       <= SEL_IF;
            we_q        <= 1'b0;
            lat_cnt_q   <= 4'd0;
            dm_streak_q <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            lat_cnt_q   <= lat_cnt_d;
            dm_streak_q <= dm_streak_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_ack    = dm_ack_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule
